// File: rtl/pg_prefix_sum16_if.sv
// Handshake/data bundle between a PG generation stage and pg_prefix_sum16.
// The master drives operands and accepts results; the slave is the adder.
interface pg_prefix_sum16_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] pg_in;
  logic               cin;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               pg_err;

  modport master (
    output in_valid, pg_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout, pg_err
  );

  modport slave (
    input  in_valid, pg_in, cin, out_ready,
    output in_ready, out_valid, sum, cout, pg_err
  );
endinterface

// File: rtl/pg_prefix_sum16.sv
// Time-folded Kogge-Stone carry resolution: takes per-bit {p,g} pairs and
// evaluates one prefix level per clock, then presents sum/cout/pg_err
// with a valid/ready handshake. One operation in flight at a time.
module pg_prefix_sum16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pg_prefix_sum16_if.slave   bus
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LVL_W  = $clog2(LEVELS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LVL_W-1:0]   level_r;
  logic [WIDTH-1:0]   g_r;
  logic [WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]   p_orig_r;
  logic               cin_r;
  logic               err_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               pg_err_r;

  logic [WIDTH-1:0]   p_in_s;
  logic [WIDTH-1:0]   g_in_s;
  logic [WIDTH-1:0]   g_nxt_s;
  logic [WIDTH-1:0]   p_nxt_s;
  logic               last_level_s;
  int                 dist_s;

  // Flags any pair that claims both propagate and generate ({1,1}).
  function automatic logic pg_illegal(input logic [WIDTH-1:0] p,
                                      input logic [WIDTH-1:0] g);
    return |(p & g);
  endfunction

  // Split the packed {p_i, g_i} pairs into separate vectors.
  always_comb begin
    p_in_s = '0;
    g_in_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p_in_s[i] = bus.pg_in[2*i+1];
      g_in_s[i] = bus.pg_in[2*i];
    end
  end

  // One Kogge-Stone level at distance 2^level; low bits below the distance pass through.
  always_comb begin
    g_nxt_s = g_r;
    p_nxt_s = p_r;
    dist_s  = 32'sd1 <<< level_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= dist_s) begin
        g_nxt_s[i] = g_r[i] | (p_r[i] & g_r[i-dist_s]);
        p_nxt_s[i] = p_r[i] & p_r[i-dist_s];
      end else begin
        g_nxt_s[i] = g_r[i];
        p_nxt_s[i] = p_r[i];
      end
    end
  end

  assign last_level_s = (level_r == LVL_W'(LEVELS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode for IDLE -> PREFIX -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = ST_PREFIX;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREFIX: begin
        if (last_level_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_PREFIX;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, per-level G/P update and registered result/handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r     <= '0;
      g_r         <= '0;
      p_r         <= '0;
      p_orig_r    <= '0;
      cin_r       <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      pg_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            p_orig_r <= p_in_s;
            p_r      <= p_in_s;
            // Fold cin into bit 0 so the prefix network carries it like any generate.
            g_r      <= {g_in_s[WIDTH-1:1], g_in_s[0] | (p_in_s[0] & bus.cin)};
            cin_r    <= bus.cin;
            err_r    <= pg_illegal(p_in_s, g_in_s);
            level_r  <= '0;
          end
        end
        ST_PREFIX: begin
          g_r     <= g_nxt_s;
          p_r     <= p_nxt_s;
          level_r <= level_r + LVL_W'(1);
          if (last_level_s) begin
            sum_r       <= p_orig_r ^ {g_nxt_s[WIDTH-2:0], cin_r};
            cout_r      <= g_nxt_s[WIDTH-1];
            pg_err_r    <= err_r;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.pg_err    = pg_err_r;

endmodule

// File: tb/tb_pg_prefix_sum16.sv
// Directed and random checks of pg_prefix_sum16: arithmetic, latency,
// backpressure, ignored input while busy, illegal pairs and async reset.
module tb_pg_prefix_sum16;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  pg_prefix_sum16_if #(.WIDTH(WIDTH)) bus ();

  pg_prefix_sum16 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] build_pg(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] pg;
    pg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pg[2*i+1] = a[i] ^ b[i];
      pg[2*i]   = a[i] & b[i];
    end
    return pg;
  endfunction

  // Present one operation at a negedge; returns after the accept edge (at the following negedge).
  task automatic issue(input logic [2*WIDTH-1:0] pg, input logic c);
    check_value("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.pg_in    = pg;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.pg_in    = '0;
    bus.cin      = 1'b0;
  endtask

  // Wait for out_valid (bounded) and check latency counted from the accept edge.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_value({tag, "_latency"}, lat, 32'd4);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] exp_sum,
                              input logic exp_cout, input logic exp_err);
    check_value({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_value({tag, "_sum"},   {16'd0, bus.sum},       {16'd0, exp_sum});
    check_value({tag, "_cout"},  {31'd0, bus.cout},      {31'd0, exp_cout});
    check_value({tag, "_err"},   {31'd0, bus.pg_err},    {31'd0, exp_err});
  endtask

  // Accept the result for one edge and confirm the block returns to IDLE.
  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_value({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check_value({tag, "_ready_back"}, {31'd0, bus.in_ready},  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    issue(build_pg(a, b), c);
    wait_result(tag);
    check_result(tag, exp_sum, exp_cout, 1'b0);
    release_result(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   rexp;
    logic [2*WIDTH-1:0] pg_bad;

    n_compared    = 0;
    n_mismatched  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pg_in     = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check_value("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_value("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_value("rst_sum",       {16'd0, bus.sum},       32'd0);
    check_value("rst_cout",      {31'd0, bus.cout},      32'd0);
    check_value("rst_pg_err",    {31'd0, bus.pg_err},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed arithmetic.
    run_op("ff_plus_1",    16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_op("wrap_b1",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("wrap_cin",     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("mixed_cin",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

    // Backpressure with an ignored second request while busy.
    issue(build_pg(16'h1234, 16'h4321), 1'b1);
    wait_result("bp");
    check_result("bp", 16'h5556, 1'b0, 1'b0);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.pg_in    = build_pg(16'h0F0F, 16'h00F1);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check_value("bp_sum_hold",   {16'd0, bus.sum},       {16'd0, held_sum});
      check_value("bp_cout_hold",  {31'd0, bus.cout},      {31'd0, held_cout});
      check_value("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
      check_value("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.pg_in    = '0;
    release_result("bp");
    check_value("bp_sum_retained", {16'd0, bus.sum}, 32'h5556);
    run_op("after_bp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Illegal pair at index 5 ({1,1}); G/P rules give sum bits 5 and 6 set.
    pg_bad = '0;
    pg_bad[11] = 1'b1;
    pg_bad[10] = 1'b1;
    issue(pg_bad, 1'b0);
    wait_result("illegal");
    check_result("illegal", 16'h0060, 1'b0, 1'b1);
    release_result("illegal");

    // Asynchronous reset while level 2 is pending.
    issue(build_pg(16'h7777, 16'h1111), 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_value("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_value("midrst_no_pulse", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Random operations with random consumer stalls.
    for (int n = 0; n < 2000; n++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom_range(1, 0));
      rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      issue(build_pg(ra, rb), rc);
      wait_result("rand");
      for (int s = 0; s < int'($urandom_range(3, 0)); s++) begin
        @(negedge clk);
      end
      check_result("rand", rexp[WIDTH-1:0], rexp[WIDTH], 1'b0);
      release_result("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
